// File: rtl/cipher_pkg.sv
// Shared encodings and default parameters for the modular cipher stream.
package cipher_pkg;

   typedef enum logic [1:0] {
      MODE_RSV0 = 2'b00,
      MODE_ENC  = 2'b01,
      MODE_DEC  = 2'b10,
      MODE_RSV3 = 2'b11
   } mode_e;

   localparam int          NULL_CHAR   = 0;
   localparam int          MODULUS_DEF = 227;
   localparam logic [7:0]  CHAR_LO_DEF = 8'h61;
   localparam logic [7:0]  CHAR_HI_DEF = 8'h7A;

endpackage

// File: rtl/cipher_fifo.sv
// Power-of-two circular output buffer; head is zero whenever the buffer is empty.
module cipher_fifo
   import cipher_pkg::*;
#(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_data,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [CW-1:0]    r_count;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == LP_DEPTH);
   assign o_count   = r_count;
   assign o_data    = o_empty ? '0 : r_mem[r_rd];
   assign w_pop_ok  = i_pop & ~o_empty;
   assign w_push_ok = i_push & (~o_full | w_pop_ok);

   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr] <= i_data;
   end

   // Pointers are AW bits wide, so they wrap at DEPTH on their own.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push_ok) r_wr <= r_wr + 1'b1;
         if (w_pop_ok)  r_rd <= r_rd + 1'b1;
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/modular_cipher_stream.sv
// Shift cipher over Z_p: one registered compute stage feeding an in-order result buffer.
module modular_cipher_stream
   import cipher_pkg::*;
#(
   parameter int              DATA_W     = 8,
   parameter int              MODULUS    = MODULUS_DEF,
   parameter int              FIFO_DEPTH = 4,
   parameter logic [DATA_W-1:0] CHAR_LO  = CHAR_LO_DEF,
   parameter logic [DATA_W-1:0] CHAR_HI  = CHAR_HI_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        mode,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [DATA_W-1:0] key,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_err,
   output logic [15:0]       err_count
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [DATA_W:0] LP_MOD   = (DATA_W + 1)'(MODULUS);
   localparam logic [CW:0]     LP_DEPTH = (CW + 1)'(FIFO_DEPTH);

   logic              r_rdy_en;
   logic              r_s1_valid;
   logic [DATA_W:0]   r_s1_data;
   logic [15:0]       r_err_count;

   logic              w_accept;
   logic [DATA_W:0]   w_sum;
   logic [DATA_W:0]   w_enc;
   logic [DATA_W:0]   w_diff;
   logic [DATA_W:0]   w_dec;
   logic [DATA_W-1:0] w_result;
   logic              w_err;
   logic [DATA_W:0]   w_head;
   logic              w_full;
   logic              w_empty;
   logic [CW-1:0]     w_fifo_count;
   logic [CW:0]       w_occupancy;

   // Occupancy counts the S1 beat so every accepted beat already owns a slot.
   assign w_occupancy = {1'b0, w_fifo_count} + {{CW{1'b0}}, r_s1_valid};
   assign in_ready    = r_rdy_en & (w_occupancy < LP_DEPTH);
   assign w_accept    = in_valid & in_ready;

   always_comb begin
      w_sum    = {1'b0, in_data} + {1'b0, key};
      w_enc    = (w_sum >= LP_MOD) ? (w_sum - LP_MOD) : w_sum;
      w_diff   = {1'b0, in_data} - {1'b0, key};
      w_dec    = w_diff[DATA_W] ? (w_diff + LP_MOD) : w_diff;
      w_result = DATA_W'(NULL_CHAR);
      w_err    = 1'b1;
      if ({1'b0, key} < LP_MOD) begin
         case (mode)
            MODE_ENC: begin
               w_err    = (in_data < CHAR_LO) | (in_data > CHAR_HI);
               w_result = w_enc[DATA_W-1:0];
            end
            MODE_DEC: begin
               w_err    = ({1'b0, in_data} >= LP_MOD);
               w_result = w_dec[DATA_W-1:0];
            end
            default: w_err = 1'b1;
         endcase
      end
      if (w_err) w_result = DATA_W'(NULL_CHAR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdy_en    <= 1'b0;
         r_s1_valid  <= 1'b0;
         r_s1_data   <= '0;
         r_err_count <= '0;
      end else begin
         r_rdy_en   <= 1'b1;
         r_s1_valid <= w_accept;
         if (w_accept) r_s1_data <= {w_err, w_result};
         if (w_accept && w_err && (r_err_count != 16'hFFFF))
            r_err_count <= r_err_count + 16'd1;
      end
   end

   cipher_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (r_s1_valid),
      .i_data  (r_s1_data),
      .i_pop   (out_ready),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_fifo_count)
   );

   assign out_valid = ~w_empty;
   assign out_data  = w_head[DATA_W-1:0];
   assign out_err   = w_head[DATA_W];
   assign err_count = r_err_count;

endmodule

// File: tb/tb_modular_cipher_stream.sv
// Directed bench for modular_cipher_stream with hand-computed expectations.
module tb_modular_cipher_stream;
   import cipher_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data = 8'h00;
   logic [7:0]  key = 8'h00;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  out_data;
   logic        out_err;
   logic [15:0] err_count;

   int n_tests = 0;
   int n_fail  = 0;

   modular_cipher_stream dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .key       (key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offers one beat, waits for its result with a cycle budget, then lets it pop.
   task automatic send_and_get(input logic [1:0] m, input logic [7:0] d, input logic [7:0] k,
                               output logic [7:0] rd, output logic re, output bit got);
      got = 0; rd = 8'h00; re = 1'b0;
      out_ready = 1'b1;
      mode = m; in_data = d; key = k; in_valid = 1'b1;
      for (int i = 0; i < 10 && !in_ready; i++) step();
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (out_valid) begin
            got = 1; rd = out_data; re = out_err;
            break;
         end
         step();
      end
      step();
   endtask

   task automatic test_reset();
      #2;
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_tests++; if (out_data !== 8'h00 || out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_data got %h/%b want 00/0", out_data, out_err); end
      n_tests++; if (err_count !== 16'h0) begin n_fail++; $display("FAIL reset_err_count got %0d want 0", err_count); end
      step(); step();
      rst_n = 1'b1;
      step();
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got %b want 1", in_ready); end
   endtask

   task automatic test_decrypt_latency();
      out_ready = 1'b1;
      mode = MODE_DEC; in_data = 8'd5; key = 8'd10; in_valid = 1'b1;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL dec_ready got %b want 1", in_ready); end
      step();
      in_valid = 1'b0;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dec_lat1 out_valid got %b want 0", out_valid); end
      step();
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dec_lat2 out_valid got %b want 1", out_valid); end
      n_tests++; if (out_data !== 8'd222 || out_err !== 1'b0) begin n_fail++; $display("FAIL dec_value got %0d/%b want 222/0", out_data, out_err); end
      step();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dec_popped out_valid got %b want 0", out_valid); end
   endtask

   task automatic test_encrypt_decrypt_values();
      logic [7:0] rd; logic re; bit got;
      send_and_get(MODE_ENC, 8'h7A, 8'd200, rd, re, got);
      n_tests++; if (!got || rd !== 8'd95 || re !== 1'b0) begin n_fail++; $display("FAIL enc_wrap got %0d/%b (seen %0d) want 95/0", rd, re, got); end
      send_and_get(MODE_ENC, 8'h61, 8'd0, rd, re, got);
      n_tests++; if (!got || rd !== 8'd97 || re !== 1'b0) begin n_fail++; $display("FAIL enc_key0 got %0d/%b (seen %0d) want 97/0", rd, re, got); end
      send_and_get(MODE_ENC, 8'h70, 8'd226, rd, re, got);
      n_tests++; if (!got || rd !== 8'd111 || re !== 1'b0) begin n_fail++; $display("FAIL enc_maxkey got %0d/%b (seen %0d) want 111/0", rd, re, got); end
      send_and_get(MODE_DEC, 8'd226, 8'd0, rd, re, got);
      n_tests++; if (!got || rd !== 8'd226 || re !== 1'b0) begin n_fail++; $display("FAIL dec_maxdata got %0d/%b (seen %0d) want 226/0", rd, re, got); end
      send_and_get(MODE_DEC, 8'd0, 8'd226, rd, re, got);
      n_tests++; if (!got || rd !== 8'd1 || re !== 1'b0) begin n_fail++; $display("FAIL dec_negwrap got %0d/%b (seen %0d) want 1/0", rd, re, got); end
      send_and_get(MODE_DEC, 8'd100, 8'd100, rd, re, got);
      n_tests++; if (!got || rd !== 8'd0 || re !== 1'b0) begin n_fail++; $display("FAIL dec_zero got %0d/%b (seen %0d) want 0/0", rd, re, got); end
   endtask

   task automatic test_errors();
      logic [7:0] rd; logic re; bit got;
      send_and_get(MODE_ENC, 8'h41, 8'd5, rd, re, got);
      n_tests++; if (!got || rd !== 8'd0 || re !== 1'b1) begin n_fail++; $display("FAIL err_enc_range got %0d/%b (seen %0d) want 0/1", rd, re, got); end
      send_and_get(MODE_DEC, 8'd10, 8'd227, rd, re, got);
      n_tests++; if (!got || rd !== 8'd0 || re !== 1'b1) begin n_fail++; $display("FAIL err_key got %0d/%b (seen %0d) want 0/1", rd, re, got); end
      n_tests++; if (err_count !== 16'd2) begin n_fail++; $display("FAIL err_count2 got %0d want 2", err_count); end
      send_and_get(2'b11, 8'h62, 8'd1, rd, re, got);
      n_tests++; if (!got || rd !== 8'd0 || re !== 1'b1) begin n_fail++; $display("FAIL err_mode got %0d/%b (seen %0d) want 0/1", rd, re, got); end
      send_and_get(MODE_DEC, 8'd227, 8'd0, rd, re, got);
      n_tests++; if (!got || rd !== 8'd0 || re !== 1'b1) begin n_fail++; $display("FAIL err_dec_range got %0d/%b (seen %0d) want 0/1", rd, re, got); end
      send_and_get(MODE_ENC, 8'h7B, 8'd0, rd, re, got);
      n_tests++; if (!got || rd !== 8'd0 || re !== 1'b1) begin n_fail++; $display("FAIL err_enc_hi got %0d/%b (seen %0d) want 0/1", rd, re, got); end
      n_tests++; if (err_count !== 16'd5) begin n_fail++; $display("FAIL err_count5 got %0d want 5", err_count); end
   endtask

   task automatic test_backpressure();
      int acc = 0;
      int k = 0;
      out_ready = 1'b0;
      mode = MODE_ENC; key = 8'd1;
      for (int c = 0; c < 6; c++) begin
         in_valid = 1'b1;
         in_data  = 8'h61 + 8'(acc);
         if (in_ready) acc++;
         step();
      end
      in_valid = 1'b0;
      step();
      n_tests++; if (acc != 4) begin n_fail++; $display("FAIL bp_accepted got %0d want 4", acc); end
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low got %b want 0", in_ready); end
      n_tests++; if (out_valid !== 1'b1 || out_data !== 8'h62) begin n_fail++; $display("FAIL bp_head got %b/%h want 1/62", out_valid, out_data); end
      step(); step();
      n_tests++; if (out_data !== 8'h62 || out_err !== 1'b0) begin n_fail++; $display("FAIL bp_hold got %h/%b want 62/0", out_data, out_err); end
      out_ready = 1'b1;
      for (int c = 0; c < 20 && k < 4; c++) begin
         if (out_valid) begin
            n_tests++; if (out_data !== 8'h62 + 8'(k)) begin n_fail++; $display("FAIL bp_order[%0d] got %h want %h", k, out_data, 8'h62 + 8'(k)); end
            k++;
         end
         step();
      end
      n_tests++; if (k != 4) begin n_fail++; $display("FAIL bp_drained got %0d want 4", k); end
      n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_after ready/valid got %b/%b want 1/0", in_ready, out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_q[$];
      int sent = 0;
      int rcvd = 0;
      int e;
      logic acc, rcv;
      mode = MODE_DEC; key = 8'd7;
      for (int c = 0; c < 200 && (sent < 10 || rcvd < 10); c++) begin
         in_valid  = (sent < 10);
         in_data   = 8'(sent * 20);
         out_ready = c[0];
         acc = in_valid & in_ready;
         rcv = out_valid & out_ready;
         if (rcv) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL b2b_extra got %0d want none", out_data);
            end else begin
               if (out_data !== exp_q[0] || out_err !== 1'b0) begin n_fail++; $display("FAIL b2b_order[%0d] got %0d/%b want %0d/0", rcvd, out_data, out_err, exp_q[0]); end
               void'(exp_q.pop_front());
            end
            rcvd++;
         end
         if (acc) begin
            e = (sent * 20 - 7) % 227;
            if (e < 0) e += 227;
            exp_q.push_back(8'(e));
            sent++;
         end
         step();
      end
      in_valid = 1'b0;
      n_tests++; if (sent != 10 || rcvd != 10 || exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_count sent %0d rcvd %0d left %0d want 10/10/0", sent, rcvd, exp_q.size()); end
      out_ready = 1'b1;
      step(); step();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_dup out_valid got %b want 0", out_valid); end
   endtask

   task automatic test_reset_midstream();
      out_ready = 1'b0;
      mode = MODE_ENC; key = 8'd0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 8'h61 + 8'(i);
         step();
      end
      in_valid = 1'b0;
      step(); step();
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_buffered out_valid got %b want 1", out_valid); end
      rst_n = 1'b0;
      #1;
      n_tests++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out got %b/%h/%b want 0/00/0", out_valid, out_data, out_err); end
      n_tests++; if (in_ready !== 1'b0 || err_count !== 16'd0) begin n_fail++; $display("FAIL mid_rst_ctl ready/errs got %b/%0d want 0/0", in_ready, err_count); end
      step();
      rst_n = 1'b1;
      out_ready = 1'b1;
      step();
      mode = MODE_DEC; in_data = 8'd100; key = 8'd1; in_valid = 1'b1;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready got %b want 1", in_ready); end
      step();
      in_valid = 1'b0;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_lat1 out_valid got %b want 0", out_valid); end
      step();
      n_tests++; if (out_valid !== 1'b1 || out_data !== 8'd99 || out_err !== 1'b0) begin n_fail++; $display("FAIL mid_lat2 got %b/%0d/%b want 1/99/0", out_valid, out_data, out_err); end
      step();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale out_valid got %b want 0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_decrypt_latency();
      test_encrypt_decrypt_values();
      test_errors();
      test_backpressure();
      test_back_to_back();
      test_reset_midstream();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "time limit");
   end

endmodule
